// File: rtl/stepper_cmd_sched_pkg.sv
// Shared types and command-word field positions for the stepper command scheduler.
// Latency: none, this file holds only declarations.
// Backpressure: not applicable.
package stepper_pkg;

    // Scheduler FSM states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_WAIT_MOVE = 3'd3,
        ST_DWELL     = 3'd4
    } sched_state_e;

    // Command word layout: [31:23] dwell_ms, [22:21] mode, [20:0] target
    localparam int DWELL_MSB  = 31;
    localparam int DWELL_LSB  = 23;
    localparam int MODE_MSB   = 22;
    localparam int MODE_LSB   = 21;
    localparam int TARGET_MSB = 20;

    typedef logic [31:0] cmd_word_t;

endpackage

// File: rtl/stepper_cmd_sched_if.sv
// Command, driver and status signals of the stepper command scheduler.
// Latency: none, wiring only.
// Backpressure: cmd_valid/cmd_ready on the command side; driver side is strobe-only.
interface stepper_cmd_sched_if #(
    parameter int DEPTH = 8
);
    logic [31:0]             cmd_data;
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    abort;
    logic                    at_target;
    logic [31:0]             drv_data;
    logic                    drv_new;
    logic                    busy;
    logic                    done;
    logic [$clog2(DEPTH):0]  q_count;

    // Processor/driver side
    modport master (
        output cmd_data, cmd_valid, abort, at_target,
        input  cmd_ready, drv_data, drv_new, busy, done, q_count
    );

    // Scheduler side
    modport slave (
        input  cmd_data, cmd_valid, abort, at_target,
        output cmd_ready, drv_data, drv_new, busy, done, q_count
    );
endinterface

// File: rtl/stepper_cmd_fifo.sv
// Synchronous command FIFO with flush, full/empty flags and occupancy count.
// Latency: a word pushed at cycle N is readable at the head in cycle N+1.
// Backpressure: pushes while full and pops while empty are ignored; flush wins over both.
module stepper_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    input  logic                   wr_en_i,
    input  logic [W-1:0]           wr_data_i,
    input  logic                   rd_en_i,
    output logic [W-1:0]           rd_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign do_push   = wr_en_i && !full_o;
    assign do_pop    = rd_en_i && !empty_o;

    // Next pointers/count; power-of-two depth lets the pointers wrap naturally
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written only on an accepted push that is not being flushed
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
    end
endmodule

// File: rtl/stepper_cmd_sched.sv
// Queues motion commands and issues them one at a time to the stepper driver; optional dwell under STEPPER_SCHED_DWELL_EN.
// Latency: push into empty idle queue at N gives drv_new at N+2; done SETTLE_CYCLES+1 cycles after issue on immediate arrival.
// Backpressure: cmd_ready drops when the queue is full or abort is high; abort flushes the queue and returns to IDLE.
module stepper_cmd_sched
    import stepper_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int TICKS_PER_MS  = 100000,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               CLK100MHZ,
    input  logic               resetn,
    stepper_cmd_sched_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(SETTLE_CYCLES);

    sched_state_e  state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    cmd_word_t     last_q, last_d, head;
    logic          fifo_full, fifo_empty, pop, cmd_ready, drv_new, done;
    logic [CW-1:0] fifo_count;
`ifdef STEPPER_SCHED_DWELL_EN
    localparam int TW = $clog2(TICKS_PER_MS);
    logic [TW-1:0] tick_q, tick_d;
    logic [8:0]    ms_q, ms_d, dwell_q, dwell_d;
`endif

    // Abort blocks new writes so a flush never races with a push
    assign cmd_ready     = !fifo_full && !bus.abort;
    assign bus.cmd_ready = cmd_ready;
    assign bus.drv_new   = drv_new;
    assign bus.drv_data  = drv_new ? head : last_q;
    assign bus.busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign bus.done      = done;
    assign bus.q_count   = fifo_count;

    stepper_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk       (CLK100MHZ),
        .rst_n     (resetn),
        .flush_i   (bus.abort),
        .wr_en_i   (bus.cmd_valid && cmd_ready),
        .wr_data_i (bus.cmd_data),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    // Next state, counters and strobes; abort overrides everything last
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        last_d   = last_q;
        pop      = 1'b0;
        drv_new  = 1'b0;
        done     = 1'b0;
`ifdef STEPPER_SCHED_DWELL_EN
        tick_d   = tick_q;
        ms_d     = ms_q;
        dwell_d  = dwell_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                drv_new  = 1'b1;
                pop      = 1'b1;
                last_d   = head;
                settle_d = SW'(SETTLE_CYCLES - 1);
                state_d  = ST_SETTLE;
`ifdef STEPPER_SCHED_DWELL_EN
                dwell_d  = head[DWELL_MSB:DWELL_LSB];
`endif
            end
            ST_SETTLE: begin
                // Driver's moving flag is registered, so at_target is stale right after issue
                if (settle_q == '0) state_d  = ST_WAIT_MOVE;
                else                settle_d = settle_q - SW'(1);
            end
            ST_WAIT_MOVE: begin
                if (bus.at_target) begin
`ifdef STEPPER_SCHED_DWELL_EN
                    if (dwell_q == '0) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        tick_d  = '0;
                        ms_d    = '0;
                        state_d = ST_DWELL;
                    end
`else
                    done    = 1'b1;
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef STEPPER_SCHED_DWELL_EN
            ST_DWELL: begin
                // Finish on the tick wrap that completes the last millisecond
                if (tick_q == TW'(TICKS_PER_MS - 1)) begin
                    tick_d = '0;
                    ms_d   = ms_q + 9'd1;
                    if ((ms_q + 9'd1) == dwell_q) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Cancel any issue or completion in the abort cycle; an issued move keeps running in the driver
        if (bus.abort) begin
            state_d = ST_IDLE;
            pop     = 1'b0;
            drv_new = 1'b0;
            done    = 1'b0;
            last_d  = last_q;
        end
    end

    // State, settle counter and last issued word
    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            last_q   <= last_d;
        end
    end

`ifdef STEPPER_SCHED_DWELL_EN
    // Dwell counters
    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            tick_q  <= '0;
            ms_q    <= '0;
            dwell_q <= '0;
        end else begin
            tick_q  <= tick_d;
            ms_q    <= ms_d;
            dwell_q <= dwell_d;
        end
    end
`endif
endmodule
